// File: rtl/sb_tx_arbiter_pkg.sv
// Shared sideband TX definitions.
// Arbiter states and serializer byte defaults.
package sb_tx_arbiter_pkg;

  localparam int SB_WIDTH = 8;
  localparam logic [7:0] SB_IDLE_BYTE = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    SEND0,
    SEND1
  } sb_state_t;

endpackage

// File: rtl/sb_rr_pick.sv
// Two-way round-robin pick.
// One-hot result; favours the requester not served last.
module sb_rr_pick (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       rr_last,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    unique case (1'b1)
      (valid0 && valid1):  pick = rr_last ? 2'b01 : 2'b10;
      (valid0 && !valid1): pick = 2'b01;
      (!valid0 && valid1): pick = 2'b10;
      default:             pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/sb_tx_arbiter.sv
// Sideband TX scheduler: packet-level round-robin
// onto the serializer, one byte per WIDTH-cycle slot.
module sb_tx_arbiter
  import sb_tx_arbiter_pkg::*;
#(
  parameter int WIDTH = SB_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_BYTE =
    WIDTH'(SB_IDLE_BYTE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_valid,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_valid,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic [WIDTH-1:0] par_data,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             underrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] SLOT_LAST =
    CW'(WIDTH - 1);

  logic [CW-1:0]    slot_cnt;
  logic             slot;
  sb_state_t        state;
  sb_state_t        state_nxt;
  logic             rr_last;
  logic             rr_nxt;
  logic             und_nxt;
  logic [WIDTH-1:0] par_nxt;
  logic [1:0]       pick;
  logic             sel0;
  logic             sel1;

  assign slot = (slot_cnt == SLOT_LAST);

  sb_rr_pick u_pick (
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .rr_last (rr_last),
    .pick    (pick)
  );

  always_comb begin
    sel0 = (state == SEND0) ||
           ((state == IDLE) && pick[0]);
    sel1 = (state == SEND1) ||
           ((state == IDLE) && pick[1]);
    req0_ready = slot && req0_valid && sel0;
    req1_ready = slot && req1_valid && sel1;
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_last;
    und_nxt   = 1'b0;
    par_nxt   = IDLE_BYTE;
    if (req0_ready) begin
      par_nxt = req0_data;
    end else if (req1_ready) begin
      par_nxt = req1_data;
    end
    if (slot) begin
      unique case (state)
        IDLE: begin
          if (req0_ready) begin
            if (req0_last) rr_nxt = 1'b0;
            else state_nxt = SEND0;
          end else if (req1_ready) begin
            if (req1_last) rr_nxt = 1'b1;
            else state_nxt = SEND1;
          end
        end
        SEND0: begin
          if (!req0_valid) begin
            und_nxt = 1'b1;
          end else if (req0_last) begin
            state_nxt = IDLE;
            rr_nxt    = 1'b0;
          end
        end
        SEND1: begin
          if (!req1_valid) begin
            und_nxt = 1'b1;
          end else if (req1_last) begin
            state_nxt = IDLE;
            rr_nxt    = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt <= '0;
      state    <= IDLE;
      rr_last  <= 1'b0;
      underrun <= 1'b0;
      par_data <= IDLE_BYTE;
    end else begin
      slot_cnt <= slot ? '0 : slot_cnt + CW'(1);
      state    <= state_nxt;
      rr_last  <= rr_nxt;
      underrun <= und_nxt;
      if (slot) par_data <= par_nxt;
    end
  end

  always_comb begin
    grant = 2'b00;
    unique case (state)
      SEND0:   grant = 2'b01;
      SEND1:   grant = 2'b10;
      default: grant = 2'b00;
    endcase
    busy = (grant != 2'b00);
  end

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Scoreboard bench for sb_tx_arbiter.
// Slot-level model predicts every cycle's outputs.
module tb_sb_tx_arbiter;

  localparam int W = 8;
  localparam logic [7:0] IB = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req0_data = '0;
  logic       req0_valid = 1'b0;
  logic       req0_last = 1'b0;
  logic       req0_ready;
  logic [7:0] req1_data = '0;
  logic       req1_valid = 1'b0;
  logic       req1_last = 1'b0;
  logic       req1_ready;
  logic [7:0] par_data;
  logic [1:0] grant;
  logic       busy;
  logic       underrun;

  sb_tx_arbiter #(.WIDTH(W), .IDLE_BYTE(IB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .par_data   (par_data),
    .grant      (grant),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       gap;
  } beat_t;

  typedef struct {
    logic [7:0] par;
    logic       und;
    logic [1:0] gnt;
  } exp_t;

  beat_t q0[$];
  beat_t q1[$];
  exp_t  sb[$];

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  bit noise = 1'b1;
  int m_state = 0;
  int m_rr = 0;
  logic [7:0] cur_par = IB;
  logic [1:0] cur_gnt = 2'b00;

  logic [7:0] got[$];
  logic [7:0] slots[$];
  logic [1:0] gseq[$];
  int rdy0_cyc[$];
  int und_cnt = 0;
  int busy_cnt = 0;
  int r1_in_pkt = 0;

  function automatic beat_t bt(input logic [7:0] d,
                               input logic l);
    bt = '{d: d, last: l, gap: 1'b0};
  endfunction

  function automatic beat_t gap_bt();
    gap_bt = '{d: 8'h00, last: 1'b0, gap: 1'b1};
  endfunction

  task automatic step();
    bit slot;
    bit v0;
    bit v1;
    bit lst;
    bit e_u;
    int w;
    exp_t e;
    slot = (cyc % W == W - 1);
    w = -1;
    e_u = 1'b0;
    lst = 1'b0;
    if (slot) begin
      v0 = q0.size() > 0 && !q0[0].gap;
      v1 = q1.size() > 0 && !q1[0].gap;
      req0_valid = v0;
      req0_data = v0 ? q0[0].d : 8'hEE;
      req0_last = v0 ? q0[0].last : 1'b0;
      req1_valid = v1;
      req1_data = v1 ? q1[0].d : 8'hEE;
      req1_last = v1 ? q1[0].last : 1'b0;
      case (m_state)
        0: begin
          if (v0 && v1) w = (m_rr == 0) ? 1 : 0;
          else if (v0) w = 0;
          else if (v1) w = 1;
        end
        1: w = v0 ? 0 : -1;
        default: w = v1 ? 1 : -1;
      endcase
      e.und = (m_state != 0) && (w < 0);
      e.par = IB;
      if (w == 0) begin
        e.par = q0[0].d;
        lst = q0[0].last;
      end else if (w == 1) begin
        e.par = q1[0].d;
        lst = q1[0].last;
      end
      if (w >= 0) begin
        if (lst) begin
          m_state = 0;
          m_rr = w;
        end else begin
          m_state = w + 1;
        end
      end
      e.gnt = (m_state == 1) ? 2'b01 :
              (m_state == 2) ? 2'b10 : 2'b00;
      sb.push_back(e);
    end else if (noise) begin
      req0_valid = 1'($urandom);
      req0_data = 8'($urandom);
      req0_last = 1'($urandom);
      req1_valid = 1'($urandom);
      req1_data = 8'($urandom);
      req1_last = 1'($urandom);
    end else begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    #1;
    vecs += 2;
    if (req0_ready !== (w == 0)) begin
      errs++;
      $display("FAIL req0_ready cyc=%0d got=%b exp=%b",
               cyc, req0_ready, (w == 0));
    end
    if (req1_ready !== (w == 1)) begin
      errs++;
      $display("FAIL req1_ready cyc=%0d got=%b exp=%b",
               cyc, req1_ready, (w == 1));
    end
    if (req0_ready === 1'b1) rdy0_cyc.push_back(cyc);
    if (req1_ready === 1'b1 && grant === 2'b01)
      r1_in_pkt++;
    @(posedge clk);
    #1;
    cyc++;
    if (slot) begin
      if (w == 0) void'(q0.pop_front());
      else if (q0.size() > 0 && q0[0].gap)
        void'(q0.pop_front());
      if (w == 1) void'(q1.pop_front());
      else if (q1.size() > 0 && q1[0].gap)
        void'(q1.pop_front());
      e = sb.pop_front();
      cur_par = e.par;
      cur_gnt = e.gnt;
      e_u = e.und;
    end
    vecs += 4;
    if (par_data !== cur_par) begin
      errs++;
      $display("FAIL par_data cyc=%0d got=%h exp=%h",
               cyc, par_data, cur_par);
    end
    if (underrun !== e_u) begin
      errs++;
      $display("FAIL underrun cyc=%0d got=%b exp=%b",
               cyc, underrun, e_u);
    end
    if (grant !== cur_gnt) begin
      errs++;
      $display("FAIL grant cyc=%0d got=%b exp=%b",
               cyc, grant, cur_gnt);
    end
    if (busy !== (cur_gnt != 2'b00)) begin
      errs++;
      $display("FAIL busy cyc=%0d got=%b exp=%b",
               cyc, busy, (cur_gnt != 2'b00));
    end
    if (slot) begin
      slots.push_back(par_data);
      if (par_data !== IB) got.push_back(par_data);
      if (grant != 2'b00 &&
          (gseq.size() == 0 || gseq[$] != grant))
        gseq.push_back(grant);
    end
    if (underrun === 1'b1) und_cnt++;
    if (busy === 1'b1) busy_cnt++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    vecs += 6;
    if (par_data !== IB) begin
      errs++;
      $display("FAIL rst_par got=%h exp=%h",
               par_data, IB);
    end
    if (grant !== 2'b00) begin
      errs++;
      $display("FAIL rst_grant got=%b exp=00", grant);
    end
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_busy got=%b exp=0", busy);
    end
    if (underrun !== 1'b0) begin
      errs++;
      $display("FAIL rst_underrun got=%b exp=0",
               underrun);
    end
    if (req0_ready !== 1'b0) begin
      errs++;
      $display("FAIL rst_ready0 got=%b exp=0",
               req0_ready);
    end
    if (req1_ready !== 1'b0) begin
      errs++;
      $display("FAIL rst_ready1 got=%b exp=0",
               req1_ready);
    end
    q0.delete();
    q1.delete();
    sb.delete();
    got.delete();
    slots.delete();
    gseq.delete();
    rdy0_cyc.delete();
    und_cnt = 0;
    busy_cnt = 0;
    r1_in_pkt = 0;
    m_state = 0;
    m_rr = 0;
    cur_par = IB;
    cur_gnt = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic run_done();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 ||
            m_state != 0) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      vecs++;
      errs++;
      $display("FAIL drain_timeout got=%0d exp=<400", n);
    end
    repeat (W) step();
  endtask

  task automatic test_reset();
    noise = 1'b0;
    do_reset();
    repeat (64) step();
    vecs += 2;
    if (got.size() != 0) begin
      errs++;
      $display("FAIL idle_data got=%0d exp=0",
               got.size());
    end
    if (busy_cnt != 0) begin
      errs++;
      $display("FAIL idle_busy got=%0d exp=0", busy_cnt);
    end
    noise = 1'b1;
  endtask

  task automatic test_single_req();
    logic [7:0] ex[2];
    ex = '{8'hA5, 8'h3C};
    do_reset();
    q0.push_back(bt(8'hA5, 1'b0));
    q0.push_back(bt(8'h3C, 1'b1));
    run_done();
    vecs += 3;
    if (rdy0_cyc.size() != 2) begin
      errs++;
      $display("FAIL single_nready got=%0d exp=2",
               rdy0_cyc.size());
    end else begin
      if (rdy0_cyc[0] != 7) begin
        errs++;
        $display("FAIL single_rdy_a got=%0d exp=7",
                 rdy0_cyc[0]);
      end
      if (rdy0_cyc[1] != 15) begin
        errs++;
        $display("FAIL single_rdy_b got=%0d exp=15",
                 rdy0_cyc[1]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      vecs++;
      if (i >= got.size() || got[i] !== ex[i]) begin
        errs++;
        $display("FAIL single_seq%0d got=%h exp=%h", i,
                 (i < got.size()) ? got[i] : 8'hxx,
                 ex[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ex[4];
    ex = '{8'h21, 8'h22, 8'h11, 8'h12};
    do_reset();
    q0.push_back(bt(8'h11, 1'b0));
    q0.push_back(bt(8'h12, 1'b1));
    q1.push_back(bt(8'h21, 1'b0));
    q1.push_back(bt(8'h22, 1'b1));
    run_done();
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (i >= slots.size() || slots[i] !== ex[i]) begin
        errs++;
        $display("FAIL b2b_slot%0d got=%h exp=%h", i,
                 (i < slots.size()) ? slots[i] : 8'hxx,
                 ex[i]);
      end
    end
    vecs++;
    if (gseq.size() != 2 || gseq[0] !== 2'b10 ||
        gseq[1] !== 2'b01) begin
      errs++;
      $display("FAIL b2b_grant got=%0d/%b exp=2/10,01",
               gseq.size(),
               (gseq.size() > 0) ? gseq[0] : 2'bxx);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] ex[3];
    ex = '{8'h11, 8'h00, 8'h12};
    do_reset();
    q0.push_back(bt(8'h11, 1'b0));
    q0.push_back(gap_bt());
    q0.push_back(bt(8'h12, 1'b1));
    repeat (W) step();
    q1.push_back(bt(8'h31, 1'b0));
    q1.push_back(bt(8'h32, 1'b1));
    run_done();
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (i >= slots.size() || slots[i] !== ex[i]) begin
        errs++;
        $display("FAIL und_slot%0d got=%h exp=%h", i,
                 (i < slots.size()) ? slots[i] : 8'hxx,
                 ex[i]);
      end
    end
    vecs += 3;
    if (und_cnt != 1) begin
      errs++;
      $display("FAIL und_pulses got=%0d exp=1", und_cnt);
    end
    if (r1_in_pkt != 0) begin
      errs++;
      $display("FAIL und_ready1 got=%0d exp=0",
               r1_in_pkt);
    end
    if (got.size() != 4 || got[3] !== 8'h32) begin
      errs++;
      $display("FAIL und_after got=%0d exp=4",
               got.size());
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] ex[6];
    ex = '{8'h81, 8'h01, 8'h82, 8'h02, 8'h83, 8'h03};
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      q0.push_back(bt(8'(i), 1'b1));
      q1.push_back(bt(8'(8'h80 + i), 1'b1));
    end
    run_done();
    for (int i = 0; i < 6; i++) begin
      vecs++;
      if (i >= slots.size() || slots[i] !== ex[i]) begin
        errs++;
        $display("FAIL sb_slot%0d got=%h exp=%h", i,
                 (i < slots.size()) ? slots[i] : 8'hxx,
                 ex[i]);
      end
    end
    vecs += 2;
    if (busy_cnt != 0) begin
      errs++;
      $display("FAIL sb_busy got=%0d exp=0", busy_cnt);
    end
    if (gseq.size() != 0) begin
      errs++;
      $display("FAIL sb_grant got=%0d exp=0",
               gseq.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ex[3];
    ex = '{8'hB1, 8'hB2, 8'hB3};
    do_reset();
    q0.push_back(bt(8'hB1, 1'b0));
    q0.push_back(bt(8'hB2, 1'b0));
    q0.push_back(bt(8'hB3, 1'b1));
    while (cyc < 12) step();
    do_reset();
    for (int i = 0; i < 3; i++)
      q0.push_back(bt(ex[i], (i == 2)));
    run_done();
    vecs++;
    if (rdy0_cyc.size() == 0 || rdy0_cyc[0] != 7) begin
      errs++;
      $display("FAIL mid_first_rdy got=%0d exp=7",
               (rdy0_cyc.size() > 0) ? rdy0_cyc[0] : -1);
    end
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (i >= got.size() || got[i] !== ex[i]) begin
        errs++;
        $display("FAIL mid_seq%0d got=%h exp=%h", i,
                 (i < got.size()) ? got[i] : 8'hxx,
                 ex[i]);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_req();
    test_back_to_back();
    test_underrun();
    test_single_byte();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/sb_tx_arbiter.md
# sb_tx_arbiter

Sideband transmit scheduler that shares the 8-bit sideband serializer between two byte-stream requesters, e.g. the sideband transaction generator and the LT/ordered-set generator. It arbitrates round-robin at packet granularity and runs a slot counter in lockstep with the serializer's internal load counter. Each granted byte is presented on the serializer's `parallel_in` exactly at its load edge. When no packet is active, it fills every slot with an idle byte.

## Interface
- `WIDTH`, 8: byte width. Must match the serializer `WIDTH`; ≥2.
- `IDLE_BYTE`, 8'h00: value driven in slots with no data.
- `clk` in 1: sideband clock, shared with the serializer.
- `rst` in 1: asynchronous, active-low reset. Must be the same net that resets the serializer.
- `req0_data` in WIDTH: requester 0 byte.
- `req0_valid` in 1: requester 0 byte available.
- `req0_last` in 1: requester 0 byte is the final byte of its packet.
- `req0_ready` out 1: requester 0 byte accepted this cycle (combinational).
- `req1_data`, `req1_valid`, `req1_last`, `req1_ready`: same as requester 0.
- `par_data` out WIDTH: registered; connects to serializer `parallel_in`.
- `grant` out 2: one-hot owner of the current packet; 0 when idle.
- `busy` out 1: a packet is in progress.
- `underrun` out 1: one-cycle pulse when a granted requester misses a slot mid-packet.

## Operation
- `slot_cnt`, $clog2(WIDTH) bits, resets to 0, increments every cycle, and wraps WIDTH-1 → 0. This mirrors the serializer counter exactly.
- The slot cycle is `slot_cnt==WIDTH-1`. Its closing edge is the slot edge, where the serializer samples `par_data`.
- Acceptance happens only in a slot cycle. `reqN_ready = slot cycle & reqN_valid & selected(N)`. A byte is transferred when valid and ready are both high.
- States:
  - IDLE: in a slot cycle with any valid, pick a requester.
    - If only one requester is valid, pick it.
    - If both are valid, pick the one not served last (`rr_last`, reset 0, so requester 1 wins the first tie).
    - Accept the picked requester's byte. Go to SEND_N, or stay in IDLE if that byte has `last`.
  - SEND_N: in each slot cycle, accept from N only; the other requester is never ready.
    - If the byte has `last`: go to IDLE and set `rr_last=N`.
    - If N is not valid: load `IDLE_BYTE`, pulse `underrun`, and stay in SEND_N.
- `par_data` update at the slot edge:
  - If a byte was accepted, load the accepted byte.
  - Otherwise, load `IDLE_BYTE`.
  - `par_data` is stable for the remaining WIDTH-1 cycles.
- `rr_last` is updated at packet end, including for single-byte packets.
- `grant` and `busy` reflect SEND_N (`grant=1<<N`, `busy=1`). Single-byte packets never assert them.
- `reqN_valid`, `reqN_data` and `reqN_last` are sampled only in slot cycles. Changes at other cycles are ignored.

## Timing
- Reset values: `slot_cnt=0`, state IDLE, `par_data=IDLE_BYTE`, `grant=0`, `busy=0`, `underrun=0`, `rr_last=0`. `reqN_ready` is 0 outside slot cycles.
- The first slot cycle after reset release is cycle WIDTH-1 (cycle 0 = first cycle with `rst` high).
- Latency for a byte accepted at slot edge E:
  - It is on `par_data` from E+1.
  - The serializer loads it at edge E+WIDTH.
  - Its bit 0 appears on `ser_out` after edge E+WIDTH+1.
- Throughput: one byte per WIDTH cycles, with no gap between consecutive packets from different requesters.
- `underrun` is high for exactly the cycle after the affected slot edge.
- Reset mid-packet: all state clears immediately and the partial packet is dropped. Requesters must restart the packet from byte 0. The serializer clears on the same reset, so phase alignment is preserved.

## Structure
- Shared sideband package holds:
  - state enum (IDLE, SEND0, SEND1);
  - `SB_IDLE_BYTE` default;
  - `SB_WIDTH=8`.
- Sub-module `sb_rr_pick`: combinational 2-way round-robin pick from (`valid0`, `valid1`, `rr_last`). It returns a one-hot pick.
- The sideband TX top instantiates `sb_tx_arbiter` with its `par_data` feeding the serializer `parallel_in`.

## Test plan
- Idle after reset, no valid for 64 cycles: `par_data` stays 8'h00, `busy=0`, and no `reqN_ready` pulses.
- Requester 0 sends the packet {A5, 3C} with valid held from cycle 0:
  - `req0_ready` is high at cycles 7 and 15.
  - `par_data` is A5 at cycles 8–15 and 3C at cycles 16–23.
  - `ser_out` shows A5 LSB-first starting at cycle 17.
- Both requesters valid with 2-byte packets (0: 11,12; 1: 21,22):
  - Output order is 21, 22, 11, 12, in back-to-back slots.
  - `grant` is 2'b10, then 2'b01.
- Requester 0 drops valid for one slot mid-packet (11, –, 12):
  - `par_data` sequence is 11, 00, 12.
  - `underrun` pulses once.
  - `req1_ready` is never asserted during the packet, even with `req1_valid=1`.
- Single-byte packets (`last=1`) from both requesters repeatedly:
  - Arbitration alternates 1, 0, 1, 0.
  - `busy` and `grant` stay 0.
- Assert `rst` at cycle 12 of a 3-byte packet:
  - Outputs return to reset values immediately.
  - After release, the first `req0_ready` is at cycle 7 and the packet restarts from byte 0.
